// File: rtl/id_ex_ctrl_pipe_pkg.sv
// Shared opcode encodings and control-bundle bit positions for the ID/EX control pipeline.
package cpu_ctrl_pkg;

    localparam int CTRL_W = 12;

    // Control bundle bit indices, MSB first: {halt,RegDst,ALUSrc,MemRead,MemWrite,MemtoReg,
    // RegWrite,Lower,Higher,BEn,Br,PCS}
    localparam int CTRL_HALT     = 11;
    localparam int CTRL_REGDST   = 10;
    localparam int CTRL_ALUSRC   = 9;
    localparam int CTRL_MEMREAD  = 8;
    localparam int CTRL_MEMWRITE = 7;
    localparam int CTRL_MEMTOREG = 6;
    localparam int CTRL_REGWRITE = 5;
    localparam int CTRL_LOWER    = 4;
    localparam int CTRL_HIGHER   = 3;
    localparam int CTRL_BEN      = 2;
    localparam int CTRL_BR       = 1;
    localparam int CTRL_PCS      = 0;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_NAND = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRA  = 4'b0101;
    localparam logic [3:0] OP_ROR  = 4'b0110;
    localparam logic [3:0] OP_PADD = 4'b0111;
    localparam logic [3:0] OP_LW   = 4'b1000;
    localparam logic [3:0] OP_SW   = 4'b1001;
    localparam logic [3:0] OP_LLB  = 4'b1010;
    localparam logic [3:0] OP_LHB  = 4'b1011;
    localparam logic [3:0] OP_B    = 4'b1100;
    localparam logic [3:0] OP_BR   = 4'b1101;
    localparam logic [3:0] OP_PCS  = 4'b1110;
    localparam logic [3:0] OP_HLT  = 4'b1111;

endpackage

// File: rtl/id_ex_ctrl_pipe_if.sv
// ID-side request and EX-side control bundle of the ID/EX boundary.
// Handshake: id_valid qualifies id_instr; the producer must hold id_instr steady
// on any cycle where id_stall=1. ex_hold freezes the ID/EX register unconditionally.
interface id_ex_ctrl_pipe_if
    import cpu_ctrl_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int RADDR_W = 4,
    parameter int CNT_W   = 16
) ();
    logic [INSTR_W-1:0] id_instr;
    logic               id_valid;
    logic               ex_flush;
    logic               ex_hold;
    logic               id_stall;
    logic               ex_valid;
    logic [CTRL_W-1:0]  ex_ctrl;
    logic [RADDR_W-1:0] ex_rd;
    logic [RADDR_W-1:0] ex_rs;
    logic [RADDR_W-1:0] ex_rt;
    logic               halted;
    logic [CNT_W-1:0]   bubble_cnt;

    modport master (
        output id_instr, id_valid, ex_flush, ex_hold,
        input  id_stall, ex_valid, ex_ctrl, ex_rd, ex_rs, ex_rt, halted, bubble_cnt
    );

    modport slave (
        input  id_instr, id_valid, ex_flush, ex_hold,
        output id_stall, ex_valid, ex_ctrl, ex_rd, ex_rs, ex_rt, halted, bubble_cnt
    );
endinterface

// File: rtl/id_ex_ctrl_pipe_decode.sv
// Combinational opcode decoder: control bundle plus which register fields the instruction reads.
module cpu_ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0]        opc,
    output logic [CTRL_W-1:0] ctrl,
    output logic              uses_rs,
    output logic              uses_rt,
    output logic              uses_rd
);

    // Truth-table decode; an unknown opcode matches no item and falls to the all-zero default.
    always_comb begin
        ctrl    = '0;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        uses_rd = 1'b0;
        case (opc)
            OP_ADD, OP_SUB, OP_NAND, OP_XOR, OP_PADD: begin
                ctrl[CTRL_REGDST]   = 1'b1;
                ctrl[CTRL_REGWRITE] = 1'b1;
                uses_rs = 1'b1;
                uses_rt = 1'b1;
            end
            OP_SLL, OP_SRA, OP_ROR: begin
                ctrl[CTRL_REGDST]   = 1'b1;
                ctrl[CTRL_ALUSRC]   = 1'b1;
                ctrl[CTRL_REGWRITE] = 1'b1;
                uses_rs = 1'b1;
            end
            OP_LW: begin
                ctrl[CTRL_ALUSRC]   = 1'b1;
                ctrl[CTRL_MEMREAD]  = 1'b1;
                ctrl[CTRL_MEMTOREG] = 1'b1;
                ctrl[CTRL_REGWRITE] = 1'b1;
                uses_rs = 1'b1;
            end
            OP_SW: begin
                ctrl[CTRL_ALUSRC]   = 1'b1;
                ctrl[CTRL_MEMWRITE] = 1'b1;
                uses_rs = 1'b1;
                uses_rd = 1'b1;
            end
            OP_LLB, OP_LHB: begin
                ctrl[CTRL_REGDST]   = 1'b1;
                ctrl[CTRL_ALUSRC]   = 1'b1;
                ctrl[CTRL_REGWRITE] = 1'b1;
                ctrl[CTRL_LOWER]    = (opc == OP_LLB);
                ctrl[CTRL_HIGHER]   = (opc == OP_LHB);
                uses_rd = 1'b1;
            end
            OP_B: begin
                ctrl[CTRL_BEN] = 1'b1;
            end
            OP_BR: begin
                ctrl[CTRL_BEN] = 1'b1;
                ctrl[CTRL_BR]  = 1'b1;
                uses_rs = 1'b1;
            end
            OP_PCS: begin
                ctrl[CTRL_REGWRITE] = 1'b1;
                ctrl[CTRL_PCS]      = 1'b1;
            end
            OP_HLT: begin
                ctrl[CTRL_HALT] = 1'b1;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/id_ex_ctrl_pipe.sv
// ID/EX control register with load-use interlock, branch flush, sticky halt and bubble counter.
module id_ex_ctrl_pipe
    import cpu_ctrl_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int RADDR_W = 4,
    parameter bit R0_ZERO = 1'b1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    id_ex_ctrl_pipe_if.slave  bus
);

    logic [3:0]         opc;
    logic [RADDR_W-1:0] f_rd, f_rs, f_rt;
    logic [CTRL_W-1:0]  dec_ctrl;
    logic               uses_rs, uses_rt, uses_rd;
    logic               id_ok, load_use, src_match, make_bubble;

    assign opc  = bus.id_instr[INSTR_W-1 -: 4];
    assign f_rd = bus.id_instr[8 +: RADDR_W];
    assign f_rs = bus.id_instr[4 +: RADDR_W];
    assign f_rt = bus.id_instr[0 +: RADDR_W];

    cpu_ctrl_decode u_decode (
        .opc     (opc),
        .ctrl    (dec_ctrl),
        .uses_rs (uses_rs),
        .uses_rt (uses_rt),
        .uses_rd (uses_rd)
    );

    // Hazard detect: a load in EX whose destination is read by the ID instruction.
    always_comb begin
        src_match = (uses_rs && (f_rs == bus.ex_rd)) ||
                    (uses_rt && (f_rt == bus.ex_rd)) ||
                    (uses_rd && (f_rd == bus.ex_rd));
        load_use  = bus.ex_valid && bus.ex_ctrl[CTRL_MEMREAD] && src_match &&
                    !(R0_ZERO && (bus.ex_rd == '0));
        id_ok     = bus.id_valid && !bus.halted;
        // Flush squashes the stalled instruction anyway, so no need to hold IF/ID for it.
        bus.id_stall = bus.ex_hold || (load_use && id_ok && !bus.ex_flush);
        make_bubble  = bus.ex_flush || load_use || !id_ok;
    end

    // ID/EX register: hold > bubble > load decoded instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ex_valid <= 1'b0;
            bus.ex_ctrl  <= '0;
            bus.ex_rd    <= '0;
            bus.ex_rs    <= '0;
            bus.ex_rt    <= '0;
        end else if (!bus.ex_hold) begin
            if (make_bubble) begin
                bus.ex_valid <= 1'b0;
                bus.ex_ctrl  <= '0;
                bus.ex_rd    <= '0;
                bus.ex_rs    <= '0;
                bus.ex_rt    <= '0;
            end else begin
                bus.ex_valid <= 1'b1;
                bus.ex_ctrl  <= dec_ctrl;
                bus.ex_rd    <= f_rd;
                bus.ex_rs    <= f_rs;
                bus.ex_rt    <= f_rt;
            end
        end
    end

    // Sticky halt: set when a valid HLT actually enters EX, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.halted <= 1'b0;
        end else if (!bus.ex_hold && !make_bubble && dec_ctrl[CTRL_HALT]) begin
            bus.halted <= 1'b1;
        end
    end

    // Saturating count of hazard bubbles (flush or load-use), frozen while held.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.bubble_cnt <= '0;
        end else if (!bus.ex_hold && (bus.ex_flush || load_use) &&
                     (bus.bubble_cnt != {CNT_W{1'b1}})) begin
            bus.bubble_cnt <= bus.bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// Directed bench for id_ex_ctrl_pipe. Three instances share one stimulus stream:
// the default build, one with R0_ZERO=0, and one with a 2-bit bubble counter.
module tb_id_ex_ctrl_pipe;
    import cpu_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic [15:0] drv_instr;
    logic        drv_valid;
    logic        drv_flush;
    logic        drv_hold;

    int tests_run = 0;
    int tests_failed = 0;

    logic [11:0] exp_ctrl [16];

    always #5 clk = ~clk;

    id_ex_ctrl_pipe_if #(.INSTR_W(16), .RADDR_W(4), .CNT_W(16)) bus_m ();
    id_ex_ctrl_pipe_if #(.INSTR_W(16), .RADDR_W(4), .CNT_W(16)) bus_z ();
    id_ex_ctrl_pipe_if #(.INSTR_W(16), .RADDR_W(4), .CNT_W(2))  bus_s ();

    assign bus_m.id_instr = drv_instr;
    assign bus_m.id_valid = drv_valid;
    assign bus_m.ex_flush = drv_flush;
    assign bus_m.ex_hold  = drv_hold;
    assign bus_z.id_instr = drv_instr;
    assign bus_z.id_valid = drv_valid;
    assign bus_z.ex_flush = drv_flush;
    assign bus_z.ex_hold  = drv_hold;
    assign bus_s.id_instr = drv_instr;
    assign bus_s.id_valid = drv_valid;
    assign bus_s.ex_flush = drv_flush;
    assign bus_s.ex_hold  = drv_hold;

    id_ex_ctrl_pipe #(.INSTR_W(16), .RADDR_W(4), .R0_ZERO(1'b1), .CNT_W(16)) dut (
        .clk (clk), .rst (rst), .bus (bus_m)
    );
    id_ex_ctrl_pipe #(.INSTR_W(16), .RADDR_W(4), .R0_ZERO(1'b0), .CNT_W(16)) dut_r0 (
        .clk (clk), .rst (rst), .bus (bus_z)
    );
    id_ex_ctrl_pipe #(.INSTR_W(16), .RADDR_W(4), .R0_ZERO(1'b1), .CNT_W(2)) dut_sat (
        .clk (clk), .rst (rst), .bus (bus_s)
    );

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs, input logic [3:0] rt);
        return {op, rd, rs, rt};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and leave a margin before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] instr, input logic fl, input logic hd);
        drv_valid = v;
        drv_instr = instr;
        drv_flush = fl;
        drv_hold  = hd;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b1, mk(OP_ADD, 4'd1, 4'd2, 4'd3), 1'b0, 1'b0);
        step();
        step();
        rst = 1'b0;
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    initial begin
        // Hand-derived control bundles from the decode truth table.
        exp_ctrl[0]  = 12'h420; exp_ctrl[1]  = 12'h420; exp_ctrl[2]  = 12'h420; exp_ctrl[3]  = 12'h420;
        exp_ctrl[4]  = 12'h620; exp_ctrl[5]  = 12'h620; exp_ctrl[6]  = 12'h620; exp_ctrl[7]  = 12'h420;
        exp_ctrl[8]  = 12'h360; exp_ctrl[9]  = 12'h280; exp_ctrl[10] = 12'h630; exp_ctrl[11] = 12'h628;
        exp_ctrl[12] = 12'h004; exp_ctrl[13] = 12'h006; exp_ctrl[14] = 12'h021; exp_ctrl[15] = 12'h800;

        rst = 1'b1;
        drive(1'b0, 16'h0000, 1'b0, 1'b0);

        // Reset, with a valid instruction present to show reset overrides it.
        do_reset();
        chk("rst_ex_valid", bus_m.ex_valid, 0);
        chk("rst_ex_ctrl", bus_m.ex_ctrl, 0);
        chk("rst_ex_rd", bus_m.ex_rd, 0);
        chk("rst_halted", bus_m.halted, 0);
        chk("rst_bubble_cnt", bus_m.bubble_cnt, 0);

        // Opcode sweep; the LW destination is kept clear of the SW that follows it.
        for (int op = 0; op < 16; op++) begin
            logic [3:0] rd;
            rd = (op == 8) ? 4'hE : 4'h5;
            drive(1'b1, mk(4'(op), rd, 4'h1, 4'h2), 1'b0, 1'b0);
            chk($sformatf("sweep_stall_op%0d", op), bus_m.id_stall, 0);
            step();
            chk($sformatf("sweep_ctrl_op%0d", op), bus_m.ex_ctrl, exp_ctrl[op]);
            chk($sformatf("sweep_valid_op%0d", op), bus_m.ex_valid, 1);
            chk($sformatf("sweep_rd_op%0d", op), bus_m.ex_rd, rd);
            chk($sformatf("sweep_rs_op%0d", op), bus_m.ex_rs, 1);
            chk($sformatf("sweep_rt_op%0d", op), bus_m.ex_rt, 2);
        end
        chk("halt_set", bus_m.halted, 1);
        chk("sweep_no_bubbles", bus_m.bubble_cnt, 0);

        // While halted, ADDs become bubbles; halted stays set.
        drive(1'b1, mk(OP_ADD, 4'd1, 4'd2, 4'd3), 1'b0, 1'b0);
        chk("halted_no_stall", bus_m.id_stall, 0);
        step();
        chk("halted_bubble_valid", bus_m.ex_valid, 0);
        chk("halted_bubble_ctrl", bus_m.ex_ctrl, 0);
        step();
        chk("halted_sticky", bus_m.halted, 1);
        chk("halted_bubble_valid2", bus_m.ex_valid, 0);

        // Hold: PCS in EX frozen for 3 cycles while a LW waits in ID.
        do_reset();
        chk("rst_clears_halt", bus_m.halted, 0);
        drive(1'b1, mk(OP_PCS, 4'd7, 4'd0, 4'd0), 1'b0, 1'b0);
        step();
        chk("hold_pre_ctrl", bus_m.ex_ctrl, 12'h021);
        drive(1'b1, mk(OP_LW, 4'd2, 4'd4, 4'd0), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("hold_stall_%0d", i), bus_m.id_stall, 1);
            step();
            chk($sformatf("hold_ctrl_%0d", i), bus_m.ex_ctrl, 12'h021);
            chk($sformatf("hold_rd_%0d", i), bus_m.ex_rd, 7);
            chk($sformatf("hold_valid_%0d", i), bus_m.ex_valid, 1);
        end
        drive(1'b1, mk(OP_LW, 4'd2, 4'd4, 4'd0), 1'b0, 1'b0);
        chk("hold_release_stall", bus_m.id_stall, 0);
        step();
        chk("hold_release_ctrl", bus_m.ex_ctrl, 12'h360);
        chk("hold_release_rd", bus_m.ex_rd, 2);

        // Load-use: LW R3 then ADD R1,R3,R2.
        do_reset();
        drive(1'b1, mk(OP_LW, 4'd3, 4'd0, 4'd0), 1'b0, 1'b0);
        step();
        drive(1'b1, mk(OP_ADD, 4'd1, 4'd3, 4'd2), 1'b0, 1'b0);
        chk("lu_stall", bus_m.id_stall, 1);
        step();
        chk("lu_bubble_valid", bus_m.ex_valid, 0);
        chk("lu_bubble_cnt", bus_m.bubble_cnt, 1);
        chk("lu_stall_clear", bus_m.id_stall, 0);
        step();
        chk("lu_add_valid", bus_m.ex_valid, 1);
        chk("lu_add_ctrl", bus_m.ex_ctrl, 12'h420);
        chk("lu_add_rd", bus_m.ex_rd, 1);
        chk("lu_cnt_after", bus_m.bubble_cnt, 1);

        // R0 exemption: LW R0 then ADD R1,R0,R2.
        do_reset();
        drive(1'b1, mk(OP_LW, 4'd0, 4'd5, 4'd0), 1'b0, 1'b0);
        step();
        drive(1'b1, mk(OP_ADD, 4'd1, 4'd0, 4'd2), 1'b0, 1'b0);
        chk("r0_zero_no_stall", bus_m.id_stall, 0);
        chk("r0_plain_stall", bus_z.id_stall, 1);
        step();
        chk("r0_zero_add_valid", bus_m.ex_valid, 1);
        chk("r0_plain_bubble", bus_z.ex_valid, 0);
        chk("r0_plain_cnt", bus_z.bubble_cnt, 1);
        chk("r0_zero_cnt", bus_m.bubble_cnt, 0);

        // Flush together with a load-use hazard: one bubble, counted once.
        do_reset();
        drive(1'b1, mk(OP_LW, 4'd3, 4'd0, 4'd0), 1'b0, 1'b0);
        step();
        drive(1'b1, mk(OP_ADD, 4'd1, 4'd3, 4'd2), 1'b1, 1'b0);
        chk("fl_lu_no_stall", bus_m.id_stall, 0);
        step();
        chk("fl_lu_bubble", bus_m.ex_valid, 0);
        chk("fl_lu_cnt", bus_m.bubble_cnt, 1);
        // HLT squashed by flush never sets halted.
        drive(1'b1, mk(OP_HLT, 4'd0, 4'd0, 4'd0), 1'b1, 1'b0);
        step();
        chk("fl_hlt_halted", bus_m.halted, 0);
        chk("fl_hlt_valid", bus_m.ex_valid, 0);
        chk("fl_hlt_cnt", bus_m.bubble_cnt, 2);

        // Saturation: five flushes into a 2-bit counter.
        do_reset();
        drive(1'b1, mk(OP_ADD, 4'd1, 4'd2, 4'd3), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step();
        chk("sat_cnt", bus_s.bubble_cnt, 3);
        chk("sat_wide_cnt", bus_m.bubble_cnt, 5);
        do_reset();
        chk("sat_rst_cnt", bus_s.bubble_cnt, 0);

        // Reset arriving during a load-use stall drops the hazard.
        drive(1'b1, mk(OP_LW, 4'd3, 4'd0, 4'd0), 1'b0, 1'b0);
        step();
        drive(1'b1, mk(OP_ADD, 4'd1, 4'd3, 4'd2), 1'b0, 1'b0);
        chk("rs_stall_before", bus_m.id_stall, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rs_valid", bus_m.ex_valid, 0);
        chk("rs_cnt", bus_m.bubble_cnt, 0);
        chk("rs_no_stall", bus_m.id_stall, 0);
        step();
        chk("rs_add_valid", bus_m.ex_valid, 1);
        chk("rs_add_ctrl", bus_m.ex_ctrl, 12'h420);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
